// File: rtl/four_bit_div_pkg.sv
// Shared types and constants for the sequential 4-bit restoring divider.
package four_bit_div_pkg;

   localparam int unsigned W          = 4;
   localparam int unsigned CNT_W      = $clog2(W);
   localparam int unsigned MAG_W      = W + 1;

   localparam int unsigned SW_MODE    = 0;
   localparam int unsigned SW_B_LSB   = 1;
   localparam int unsigned SW_A_LSB   = 1 + W;

   localparam int unsigned LEDG_Q_LSB = 0;
   localparam int unsigned LEDG_R_LSB = W;
   localparam int unsigned LEDG_DONE  = 2 * W;
   localparam int unsigned LEDG_W     = 2 * W + 1;

   localparam int unsigned LEDR_OVF   = 0;
   localparam int unsigned LEDR_DZ    = 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_e;

   // Magnitude at W+1 bits so that |-2^(W-1)| is representable.
   function automatic logic [MAG_W-1:0] to_mag(input logic [W-1:0] v, input logic is_signed);
      logic [MAG_W-1:0] ext;
      ext = {is_signed & v[W-1], v};
      return (is_signed & v[W-1]) ? (MAG_W'(0) - ext) : ext;
   endfunction

endpackage

// File: rtl/four_bit_seq_divider_key_edge_sync.sv
// Push-button synchronizer with a falling-edge (press) detector.
module key_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic fall_c
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   // Reset to the released level so no spurious press follows reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         hist_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign fall_c = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/four_bit_seq_divider.sv
// Sequential 4-bit restoring divider: SW operands in, quotient/remainder/flags on LEDs.
module four_bit_seq_divider
   import four_bit_div_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        CLOCK_50,
   input  logic [1:0]  KEY,
   input  logic [8:0]  SW,
   output logic [8:0]  LEDG,
   output logic [1:0]  LEDR
);

   logic rst_n;
   logic start_c;

   assign rst_n = KEY[0];

   key_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_key_sync (
      .clk    (CLOCK_50),
      .rst_n  (rst_n),
      .key_n  (KEY[1]),
      .fall_c (start_c)
   );

   state_e              state_q,  state_d;
   logic [CNT_W-1:0]    count_q,  count_d;
   logic [W-1:0]        a_raw_q,  a_raw_d;
   logic [W-1:0]        dvd_q,    dvd_d;
   logic [W-1:0]        q_mag_q,  q_mag_d;
   logic [MAG_W-1:0]    b_mag_q,  b_mag_d;
   logic [MAG_W-1:0]    p_q,      p_d;
   logic                mode_q,   mode_d;
   logic                qsign_q,  qsign_d;
   logic                rsign_q,  rsign_d;
   logic [LEDG_W-1:0]   ledg_q,   ledg_d;
   logic [1:0]          ledr_q,   ledr_d;

   logic [W-1:0]        a_in, b_in;
   logic                mode_in;
   logic [MAG_W-1:0]    a_mag_in;
   logic [MAG_W:0]      p_shift, trial;
   logic [W-1:0]        q_signed, r_signed;
   logic                ovf;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      a_raw_d  = a_raw_q;
      dvd_d    = dvd_q;
      q_mag_d  = q_mag_q;
      b_mag_d  = b_mag_q;
      p_d      = p_q;
      mode_d   = mode_q;
      qsign_d  = qsign_q;
      rsign_d  = rsign_q;
      ledg_d   = ledg_q;
      ledr_d   = ledr_q;

      a_in     = SW[SW_A_LSB +: W];
      b_in     = SW[SW_B_LSB +: W];
      mode_in  = SW[SW_MODE];
      a_mag_in = to_mag(a_in, mode_in);

      // Trial subtraction; the extra top bit is the borrow.
      p_shift  = {p_q, dvd_q[W-1]};
      trial    = p_shift - (MAG_W+1)'(b_mag_q);

      q_signed = qsign_q ? (W'(0) - q_mag_q) : q_mag_q;
      r_signed = rsign_q ? (W'(0) - p_q[W-1:0]) : p_q[W-1:0];
      ovf      = mode_q & ~qsign_q & q_mag_q[W-1];

      case (state_q)
         IDLE, DONE: begin
            if (start_c) begin
               a_raw_d           = a_in;
               b_mag_d           = to_mag(b_in, mode_in);
               mode_d            = mode_in;
               qsign_d           = mode_in & (a_in[W-1] ^ b_in[W-1]);
               rsign_d           = mode_in & a_in[W-1];
               dvd_d             = a_mag_in[W-1:0];
               p_d               = MAG_W'(a_mag_in[W]);
               q_mag_d           = '0;
               count_d           = CNT_W'(W - 1);
               ledg_d[LEDG_DONE] = 1'b0;
               ledr_d            = '0;
               state_d           = (b_in == '0) ? FIX : CALC;
            end
         end
         CALC: begin
            dvd_d = {dvd_q[W-2:0], 1'b0};
            if (!trial[MAG_W]) begin
               p_d     = trial[MAG_W-1:0];
               q_mag_d = {q_mag_q[W-2:0], 1'b1};
            end else begin
               p_d     = p_shift[MAG_W-1:0];
               q_mag_d = {q_mag_q[W-2:0], 1'b0};
            end
            if (count_q == '0) begin
               state_d = FIX;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         FIX: begin
            ledg_d[LEDG_DONE] = 1'b1;
            ledr_d            = '0;
            if (b_mag_q == '0) begin
               ledg_d[LEDG_Q_LSB +: W] = '1;
               ledg_d[LEDG_R_LSB +: W] = a_raw_q;
               ledr_d[LEDR_DZ]         = 1'b1;
            end else if (ovf) begin
               ledg_d[LEDG_Q_LSB +: W] = q_mag_q;
               ledg_d[LEDG_R_LSB +: W] = '0;
               ledr_d[LEDR_OVF]        = 1'b1;
            end else begin
               ledg_d[LEDG_Q_LSB +: W] = q_signed;
               ledg_d[LEDG_R_LSB +: W] = r_signed;
            end
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         a_raw_q <= '0;
         dvd_q   <= '0;
         q_mag_q <= '0;
         b_mag_q <= '0;
         p_q     <= '0;
         mode_q  <= 1'b0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         ledg_q  <= '0;
         ledr_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         a_raw_q <= a_raw_d;
         dvd_q   <= dvd_d;
         q_mag_q <= q_mag_d;
         b_mag_q <= b_mag_d;
         p_q     <= p_d;
         mode_q  <= mode_d;
         qsign_q <= qsign_d;
         rsign_q <= rsign_d;
         ledg_q  <= ledg_d;
         ledr_q  <= ledr_d;
      end
   end

   assign LEDG = ledg_q;
   assign LEDR = ledr_q;

endmodule

// File: tb/tb_four_bit_seq_divider.sv
// Directed, table-driven bench for four_bit_seq_divider.
module tb_four_bit_seq_divider;

   logic       CLOCK_50 = 1'b0;
   logic [1:0] KEY;
   logic [8:0] SW;
   logic [8:0] LEDG;
   logic [1:0] LEDR;

   int n_checks = 0;
   int n_fail   = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   four_bit_seq_divider #(
      .SYNC_STAGES (2)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .KEY      (KEY),
      .SW       (SW),
      .LEDG     (LEDG),
      .LEDR     (LEDR)
   );

   typedef struct {
      string      name;
      logic [8:0] sw;
      logic [3:0] q;
      logic [3:0] r;
      logic [1:0] ledr;
      int         lat;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Press from a negedge; press counts as cycle 0 of the synchronizer, so
   // results appear lat+2 edges later (two synchronizer edges before the pulse).
   task automatic run_op(input string name, input logic [8:0] sw_v, input logic [3:0] eq,
                         input logic [3:0] er, input logic [1:0] el, input int lat);
      @(negedge CLOCK_50);
      SW     = sw_v;
      KEY[1] = 1'b0;
      for (int i = 1; i <= lat + 2; i++) begin
         @(negedge CLOCK_50);
         if (i == 2) KEY[1] = 1'b1;
         if (i == lat + 1) check({name, " early done"}, 32'(LEDG[8]), 32'(0));
      end
      check({name, " done"}, 32'(LEDG[8]), 32'(1));
      check({name, " LEDG"}, 32'(LEDG), 32'({1'b1, er, eq}));
      check({name, " LEDR"}, 32'(LEDR), 32'(el));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int drops;

      KEY = 2'b10;
      SW  = '0;
      repeat (3) @(negedge CLOCK_50);
      check("reset LEDG", 32'(LEDG), 32'(0));
      check("reset LEDR", 32'(LEDR), 32'(0));
      KEY[0] = 1'b1;
      @(negedge CLOCK_50);

      vecs[0]  = '{"u 7/2",   9'b0111_0010_0, 4'b0011, 4'b0001, 2'b00, 6};
      vecs[1]  = '{"s -7/2",  9'b1001_0010_1, 4'b1101, 4'b1111, 2'b00, 6};
      vecs[2]  = '{"u 8/15",  9'b1000_1111_0, 4'b0000, 4'b1000, 2'b00, 6};
      vecs[3]  = '{"s -8/-1", 9'b1000_1111_1, 4'b1000, 4'b0000, 2'b01, 6};
      vecs[4]  = '{"u 5/0",   9'b0101_0000_0, 4'b1111, 4'b0101, 2'b10, 2};
      vecs[5]  = '{"u 15/1",  9'b1111_0001_0, 4'b1111, 4'b0000, 2'b00, 6};
      vecs[6]  = '{"s 7/-2",  9'b0111_1110_1, 4'b1101, 4'b0001, 2'b00, 6};
      vecs[7]  = '{"s -8/2",  9'b1000_0010_1, 4'b1100, 4'b0000, 2'b00, 6};
      vecs[8]  = '{"s -3/0",  9'b1101_0000_1, 4'b1111, 4'b1101, 2'b10, 2};
      vecs[9]  = '{"u 13/4",  9'b1101_0100_0, 4'b0011, 4'b0001, 2'b00, 6};
      vecs[10] = '{"s -1/-8", 9'b1111_1000_1, 4'b0000, 4'b1111, 2'b00, 6};
      vecs[11] = '{"s -8/1",  9'b1000_0001_1, 4'b1000, 4'b0000, 2'b00, 6};
      vecs[12] = '{"s -8/-8", 9'b1000_1000_1, 4'b0001, 4'b0000, 2'b00, 6};

      for (int v = 0; v < NVEC; v++) begin
         run_op(vecs[v].name, vecs[v].sw, vecs[v].q, vecs[v].r, vecs[v].ledr, vecs[v].lat);
      end

      // Second press during CALC must be dropped; SW change after capture ignored.
      @(negedge CLOCK_50);
      SW     = 9'b1001_0011_0;
      KEY[1] = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge CLOCK_50);
         if (i == 2) KEY[1] = 1'b1;
         if (i == 3) SW = 9'b1111_0001_0;
         if (i == 4) KEY[1] = 1'b0;
         if (i == 7) check("busy early done", 32'(LEDG[8]), 32'(0));
      end
      check("busy 9/3 LEDG", 32'(LEDG), 32'({1'b1, 4'b0000, 4'b0011}));
      KEY[1] = 1'b1;
      repeat (10) @(negedge CLOCK_50);
      check("busy not queued LEDG", 32'(LEDG), 32'({1'b1, 4'b0000, 4'b0011}));
      check("busy not queued LEDR", 32'(LEDR), 32'(0));

      // Held button: exactly one operation, done never drops afterwards.
      drops = 0;
      @(negedge CLOCK_50);
      SW     = 9'b0110_0011_0;
      KEY[1] = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge CLOCK_50);
         if (i >= 8 && LEDG[8] !== 1'b1) drops++;
      end
      KEY[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLOCK_50);
         if (LEDG[8] !== 1'b1) drops++;
      end
      check("held single op", 32'(drops), 32'(0));
      check("held 6/3 LEDG", 32'(LEDG), 32'({1'b1, 4'b0000, 4'b0010}));

      // Reset during the second CALC cycle clears outputs without a clock edge.
      @(negedge CLOCK_50);
      SW     = 9'b1101_0100_0;
      KEY[1] = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge CLOCK_50);
         if (i == 2) KEY[1] = 1'b1;
      end
      check("hold during calc LEDG", 32'(LEDG), 32'({1'b0, 4'b0000, 4'b0010}));
      KEY[0] = 1'b0;
      #1;
      check("async reset LEDG", 32'(LEDG), 32'(0));
      check("async reset LEDR", 32'(LEDR), 32'(0));
      repeat (2) @(negedge CLOCK_50);
      KEY[0] = 1'b1;
      @(negedge CLOCK_50);
      check("post reset idle LEDG", 32'(LEDG), 32'(0));
      run_op("post reset 6/4", 9'b0110_0100_0, 4'b0001, 4'b0010, 2'b00, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
